count_sequencer: RTL and testbench
==================================

# count_sequencer

Command-driven controller for the design's 8-bit counting resource. It accepts start/stop/load/clear commands over a valid/ready handshake and drives the count at a programmable prescaled rate up to a programmable limit. It runs in periodic (auto-reload) or one-shot mode and flags each limit match with a single-cycle pulse. It sits between the command/configuration logic and anything that consumes `count`.

## Interface

Parameters:
- `WIDTH`, 8 — count width.
- `PRESCALE_W`, 4 — prescaler width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command can be accepted.
- `cmd_op`  in  2  command: 00 START, 01 STOP, 10 LOAD, 11 CLEAR.
- `cmd_data`  in  WIDTH  load value; used only by LOAD.
- `cfg_limit`  in  WIDTH  terminal count; sampled every cycle.
- `cfg_prescale`  in  PRESCALE_W  divide-by (`cfg_prescale`+1); sampled every cycle.
- `cfg_oneshot`  in  1  1 = stop in DONE after a match; 0 = periodic.
- `count`  out  WIDTH  current count, registered.
- `running`  out  1  state == RUN.
- `done`  out  1  state == DONE.
- `match_pulse`  out  1  one-cycle pulse per limit match, registered.

## Operation

- **FSM states:** IDLE, RUN, DONE.
- **Reset values:** state IDLE, `count` 0, prescaler 0, pending command cleared, `cmd_ready` 1, `match_pulse` 0, `running` 0, `done` 0.
- **Handshake:**
  - Transfer occurs on an edge where `cmd_valid` and `cmd_ready` are both 1.
  - The command (`cmd_op`, `cmd_data`) is registered as pending.
  - `cmd_ready` = NOT pending, so it is 0 for exactly one cycle after each transfer.
  - Pending executes on the next edge, then clears.
- **Command effects at execution edge:**
  - START:
    - IDLE or DONE → RUN; prescaler := 0; `count` unchanged.
    - In RUN: ignored; the prescaler is not disturbed.
  - STOP:
    - RUN → IDLE; `count` held.
    - In IDLE: no effect.
    - In DONE: → IDLE.
  - LOAD:
    - `count` := `cmd_data`; prescaler := 0.
    - RUN stays RUN; IDLE stays IDLE; DONE → IDLE.
  - CLEAR: `count` := 0; prescaler := 0; state → IDLE.
- **Counting in RUN:**
  - Prescaler increments every cycle.
  - Tick when prescaler ≥ `cfg_prescale`; on a tick, prescaler := 0.
  - On a tick with `count` == `cfg_limit`:
    - `count` := 0 and `match_pulse` := 1 for the following cycle.
    - If `cfg_oneshot` = 1, state → DONE.
  - On a tick otherwise: `count` := `count`+1, modulo 2^WIDTH.
  - Wrap from all-ones to 0 produces no match unless `cfg_limit` is all-ones.
  - A LOAD above `cfg_limit` therefore counts through the wrap to reach the limit.
- **Outside RUN:** IDLE and DONE hold `count` and hold the prescaler at 0.
- **Simultaneous events:**
  - A command executing on the same edge as a tick wins; that tick is discarded entirely (no increment, no match).
  - `match_pulse` is never asserted on an edge where a command executed.
- **Live configuration:**
  - A `cfg_prescale` decrease below the current prescaler value forces a tick on the next RUN edge.
  - A `cfg_limit` change takes effect at the next tick.
- **Reset mid-operation:** `rst_n` low immediately forces reset values, independent of `clk`. Any pending command is discarded.

## Timing

- Command latency: transfer at edge N → effect visible after edge N+1.
- Back-to-back commands: next transfer no earlier than edge N+2.
- Start to first increment: START executes at edge E → first increment at edge E+`cfg_prescale`+1.
- Periodic period: (`cfg_limit`+1) × (`cfg_prescale`+1) clocks between successive `match_pulse` assertions.
- `match_pulse`: high exactly one cycle, beginning after the match edge.
- One-shot: `done`/`running` change on the same edge that `match_pulse` rises.

## Test plan

- **Reset:**
  - Stimulus: assert `rst_n`=0 mid-RUN with `count`=5 between clock edges.
  - Required: immediately `count`=0, `running`=0, `cmd_ready`=1, `match_pulse`=0.
- **Periodic run:**
  - Stimulus: limit 3, prescale 0, oneshot 0; START transferred at N.
  - Required:
    - `running` from N+1.
    - `count` 1,2,3 after N+2..N+4, then 0 after N+5 with `match_pulse`=1 for that cycle.
    - Pulses repeat every 4 cycles.
- **Prescaled one-shot:**
  - Stimulus: limit 2, prescale 2, oneshot 1.
  - Required:
    - Increments every 3 cycles.
    - After 9 cycles of RUN: `count`=0, `match_pulse` one cycle, `done`=1, `running`=0.
    - A further START returns to RUN.
- **LOAD above limit:**
  - Stimulus: limit 4, prescale 0; LOAD 0xFE while RUN.
  - Required: `count` FE, FF, 00, 01 … 04; match on 04 only, none at the wrap.
- **Command/tick collision:**
  - Stimulus: STOP executes on the same edge a tick would move `count` 3→0 with limit 3.
  - Required: `count` stays 3, `match_pulse` 0, state IDLE.
- **Handshake:**
  - Stimulus: hold `cmd_valid`=1 with CLEAR for 4 cycles.
  - Required:
    - `cmd_ready` toggles 1,0,1,0, so exactly 2 transfers.
    - `count`=0 and state IDLE after each execution.

Source files
------------

// File: rtl/count_sequencer_if.sv
// Command channel for count_sequencer: a valid/ready handshake carrying
// an opcode and an optional load value.
interface count_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  // Command source side
  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  // Command sink side (the sequencer)
  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: command-driven controller for an 8-bit counting resource.
// Commands are captured into a one-deep pending slot and executed on the
// following edge; a command edge always suppresses counting on that edge.
// Counting in RUN advances once every (cfg_prescale+1) clocks up to
// cfg_limit, where it wraps to zero and emits a one-cycle match pulse.
module count_sequencer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  count_sequencer_if.slave      cmd,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_oneshot,
  output logic [WIDTH-1:0]      count,
  output logic                  running,
  output logic                  done,
  output logic                  match_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t                state_r;
  logic                  pending_r;
  logic                  ready_r;
  logic [1:0]            pend_op_r;
  logic [WIDTH-1:0]      pend_data_r;
  logic [PRESCALE_W-1:0] presc_r;
  logic [WIDTH-1:0]      count_r;
  logic                  running_r;
  logic                  done_r;
  logic                  match_r;

  logic                  tick_s;
  logic                  at_limit_s;

  // A lowered cfg_prescale below the running prescaler still fires a tick.
  assign tick_s     = (presc_r >= cfg_prescale);
  assign at_limit_s = (count_r == cfg_limit);

  assign cmd.cmd_ready = ready_r;
  assign count         = count_r;
  assign running       = running_r;
  assign done          = done_r;
  assign match_pulse   = match_r;

  // Sequencer FSM: command capture/execution, prescaler and count update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pending_r   <= 1'b0;
      ready_r     <= 1'b1;
      pend_op_r   <= 2'b00;
      pend_data_r <= {WIDTH{1'b0}};
      presc_r     <= {PRESCALE_W{1'b0}};
      count_r     <= {WIDTH{1'b0}};
      running_r   <= 1'b0;
      done_r      <= 1'b0;
      match_r     <= 1'b0;
    end else begin
      match_r <= 1'b0;
      if (pending_r) begin
        // Execution edge: the command wins over any tick on this edge.
        pending_r <= 1'b0;
        ready_r   <= 1'b1;
        case (pend_op_r)
          OP_START: begin
            if (state_r != ST_RUN) begin
              state_r   <= ST_RUN;
              presc_r   <= {PRESCALE_W{1'b0}};
              running_r <= 1'b1;
              done_r    <= 1'b0;
            end else begin
              state_r <= state_r;
            end
          end
          OP_STOP: begin
            state_r   <= ST_IDLE;
            presc_r   <= {PRESCALE_W{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
          end
          OP_LOAD: begin
            count_r <= pend_data_r;
            presc_r <= {PRESCALE_W{1'b0}};
            if (state_r == ST_DONE) begin
              state_r <= ST_IDLE;
              done_r  <= 1'b0;
            end else begin
              state_r <= state_r;
            end
          end
          OP_CLEAR: begin
            count_r   <= {WIDTH{1'b0}};
            presc_r   <= {PRESCALE_W{1'b0}};
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
            done_r    <= 1'b0;
          end
          default: begin
            state_r   <= ST_IDLE;
            presc_r   <= {PRESCALE_W{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
          end
        endcase
      end else begin
        // Capture slot is empty exactly when ready_r is high.
        if (cmd.cmd_valid && ready_r) begin
          pending_r   <= 1'b1;
          ready_r     <= 1'b0;
          pend_op_r   <= cmd.cmd_op;
          pend_data_r <= cmd.cmd_data;
        end else begin
          pending_r <= pending_r;
        end
        if (state_r == ST_RUN) begin
          if (tick_s) begin
            presc_r <= {PRESCALE_W{1'b0}};
            if (at_limit_s) begin
              count_r <= {WIDTH{1'b0}};
              match_r <= 1'b1;
              if (cfg_oneshot) begin
                state_r   <= ST_DONE;
                running_r <= 1'b0;
                done_r    <= 1'b1;
              end else begin
                state_r <= ST_RUN;
              end
            end else begin
              count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            presc_r <= presc_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
          end
        end else begin
          presc_r <= {PRESCALE_W{1'b0}};
        end
      end
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model built from the command/counting rules.
module tb_count_sequencer;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  cfg_limit;
  logic [PW-1:0] cfg_prescale;
  logic          cfg_oneshot;
  logic [W-1:0]  count;
  logic          running;
  logic          done;
  logic          match_pulse;

  count_sequencer_if #(.WIDTH(W)) cif ();

  count_sequencer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cif),
    .cfg_limit    (cfg_limit),
    .cfg_prescale (cfg_prescale),
    .cfg_oneshot  (cfg_oneshot),
    .count        (count),
    .running      (running),
    .done         (done),
    .match_pulse  (match_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
  } cmd_t;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  cmd_t waiting[$];      // accepted but not yet executed commands
  int   m_mode   = M_IDLE;
  int   m_count  = 0;
  int   m_since  = 0;    // clocks spent in the current prescale window
  int   m_match  = 0;
  int   n_xfer   = 0;
  bit   m_take;
  cmd_t m_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waiting.delete();
      m_mode  = M_IDLE;
      m_count = 0;
      m_since = 0;
      m_match = 0;
    end else begin
      m_take  = cif.cmd_valid && (waiting.size() == 0);
      m_match = 0;
      if (waiting.size() > 0) begin
        m_c = waiting.pop_front();
        case (m_c.op)
          2'b00: if (m_mode != M_RUN) begin m_mode = M_RUN; m_since = 0; end
          2'b01: begin m_mode = M_IDLE; m_since = 0; end
          2'b10: begin
            m_count = m_c.data;
            m_since = 0;
            if (m_mode == M_DONE) m_mode = M_IDLE;
          end
          default: begin m_count = 0; m_since = 0; m_mode = M_IDLE; end
        endcase
      end else if (m_mode == M_RUN) begin
        if (m_since >= int'(cfg_prescale)) begin
          m_since = 0;
          if (m_count == int'(cfg_limit)) begin
            m_count = 0;
            m_match = 1;
            if (cfg_oneshot) m_mode = M_DONE;
          end else begin
            m_count = (m_count + 1) % 256;
          end
        end else begin
          m_since = m_since + 1;
        end
      end
      if (m_take) begin
        waiting.push_back({cif.cmd_op, cif.cmd_data});
        n_xfer++;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    check("count",   int'(count),         m_count);
    check("running", int'(running),       int'(m_mode == M_RUN));
    check("done",    int'(done),          int'(m_mode == M_DONE));
    check("match",   int'(match_pulse),   m_match);
    check("ready",   int'(cif.cmd_ready), int'(waiting.size() == 0));
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] op, input logic [7:0] data);
    int guard;
    guard = 0;
    while (!cif.cmd_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!cif.cmd_ready) check("send_ready_timeout", 0, 1);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = data;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic set_cfg(input int lim, input int pre, input int one);
    cfg_limit    = lim[W-1:0];
    cfg_prescale = pre[PW-1:0];
    cfg_oneshot  = one[0];
  endtask

  int xfer0;

  initial begin
    rst_n         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_data  = 8'h00;
    set_cfg(3, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_ready", int'(cif.cmd_ready), 1);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Periodic run: limit 3, prescale 0
    send(2'b00, 8'h00);
    @(negedge clk);
    check("per_running", int'(running), 1);
    check("per_c0", int'(count), 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("per_inc", int'(count), k);
      check("per_nomatch", int'(match_pulse), 0);
    end
    @(negedge clk);
    check("per_wrap", int'(count), 0);
    check("per_match1", int'(match_pulse), 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("per_inc2", int'(count), k);
      check("per_gap", int'(match_pulse), 0);
    end
    @(negedge clk);
    check("per_match2", int'(match_pulse), 1);

    // Command/tick collision: STOP executes where 3 -> 0 would happen
    repeat (2) @(negedge clk);
    send(2'b01, 8'h00);
    check("col_pre", int'(count), 3);
    @(negedge clk);
    check("col_count", int'(count), 3);
    check("col_match", int'(match_pulse), 0);
    check("col_idle", int'(running), 0);

    // Prescaled one-shot: limit 2, prescale 2
    send(2'b11, 8'h00);
    @(negedge clk);
    check("clr_count", int'(count), 0);
    set_cfg(2, 2, 1);
    send(2'b00, 8'h00);
    @(negedge clk);
    check("os_running", int'(running), 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("os_count", int'(count), (k < 9) ? k / 3 : 0);
      check("os_match", int'(match_pulse), int'(k == 9));
      check("os_done", int'(done), int'(k == 9));
      check("os_run", int'(running), int'(k != 9));
    end
    @(negedge clk);
    check("os_pulse_end", int'(match_pulse), 0);
    check("os_hold_done", int'(done), 1);
    send(2'b00, 8'h00);
    @(negedge clk);
    check("os_restart", int'(running), 1);
    check("os_restart_done", int'(done), 0);

    // LOAD above limit: wraps through 0xFF to reach limit 4
    set_cfg(4, 0, 0);
    send(2'b10, 8'hFE);
    @(negedge clk);
    check("ld_fe", int'(count), 254);
    begin
      int seq[6] = '{255, 0, 1, 2, 3, 4};
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        check("ld_seq", int'(count), seq[k]);
        check("ld_nomatch", int'(match_pulse), 0);
      end
    end
    @(negedge clk);
    check("ld_match_cnt", int'(count), 0);
    check("ld_match", int'(match_pulse), 1);

    // Handshake: CLEAR held valid for 4 cycles
    xfer0 = n_xfer;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'b11;
    cif.cmd_data  = 8'h00;
    check("hs_r0", int'(cif.cmd_ready), 1);
    @(negedge clk);
    check("hs_r1", int'(cif.cmd_ready), 0);
    @(negedge clk);
    check("hs_r2", int'(cif.cmd_ready), 1);
    check("hs_cnt1", int'(count), 0);
    check("hs_idle1", int'(running), 0);
    @(negedge clk);
    check("hs_r3", int'(cif.cmd_ready), 0);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    check("hs_cnt2", int'(count), 0);
    check("hs_idle2", int'(running), 0);
    check("hs_xfers", n_xfer - xfer0, 2);

    // Reset mid-run with count 5, between clock edges
    set_cfg(10, 0, 0);
    send(2'b00, 8'h00);
    repeat (6) @(negedge clk);
    check("mr_pre", int'(count), 5);
    #2 rst_n = 1'b0;
    #1;
    check("mr_count", int'(count), 0);
    check("mr_running", int'(running), 0);
    check("mr_ready", int'(cif.cmd_ready), 1);
    check("mr_match", int'(match_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        cfg_limit    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
        cfg_prescale = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
        cfg_oneshot  = 1'($urandom_range(0, 1));
      end
      cif.cmd_valid = ($urandom_range(0, 7) == 0);
      cif.cmd_op    = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
      cif.cmd_data  = 8'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check("rnd_rst_count", int'(count), 0);
        check("rnd_rst_ready", int'(cif.cmd_ready), 1);
        check("rnd_rst_match", int'(match_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    cif.cmd_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
